// File: rtl/systolic_skew_feeder.sv
// Operand buffer and diagonal-skew feeder for an NxN output-stationary systolic array.
// Holds one A and one B matrix and streams them onto the array edges with per-row/column delay.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(3*N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_mat,
  input  logic [IW-1:0]         ld_idx,
  input  logic [N-1:0][DW-1:0]  ld_row,
  input  logic                  start,
  output logic                  busy,
  output logic                  acc_clr,
  output logic [N-1:0][DW-1:0]  A_in,
  output logic [N-1:0][DW-1:0]  B_in,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, CLR, FEED, DRAIN} state_t;

  // Last skew step carrying data, and the step at which PE[N-1][N-1] takes its final product.
  localparam logic [CW-1:0] FEED_LAST  = CW'(2*N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(3*N - 3);

  state_t                      state, state_nxt;
  logic [CW-1:0]               t, t_nxt;
  logic                        done_nxt;
  logic [N-1:0][N-1:0][DW-1:0] buf_a, buf_b;
  logic [N-1:0][DW-1:0]        a_nxt, b_nxt;

  assign busy     = (state != IDLE);
  assign ld_ready = (state == IDLE);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    state_nxt = state;
    t_nxt     = t;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLR;
          t_nxt     = '0;
        end
      end
      CLR: begin
        state_nxt = FEED;
        t_nxt     = '0;
      end
      FEED: begin
        t_nxt = t + CW'(1);
        if (t == FEED_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (t == DRAIN_LAST) begin
          state_nxt = IDLE;
          t_nxt     = '0;
          done_nxt  = 1'b1;
        end else begin
          t_nxt = t + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row i of A enters at step i and column j of B at step j: element k appears at step i+k / j+k.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    if (state_nxt == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (t_nxt == CW'(i + k)) begin
            a_nxt[i] = buf_a[i][k];
            b_nxt[i] = buf_b[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      t       <= '0;
      acc_clr <= 1'b0;
      done    <= 1'b0;
      A_in    <= '0;
      B_in    <= '0;
      // NOTE: the buffers are reset too, so a run straight after reset computes from zeros.
      buf_a   <= '0;
      buf_b   <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so each register samples pre-edge values.
      state   <= state_nxt;
      t       <= t_nxt;
      acc_clr <= (state_nxt == CLR);
      done    <= done_nxt;
      A_in    <= a_nxt;
      B_in    <= b_nxt;
      if (ld_valid && state == IDLE) begin
        if (ld_mat) buf_b[ld_idx] <= ld_row;
        else        buf_a[ld_idx] <= ld_row;
      end
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: drives a behavioural PE array from the feeder outputs and
// checks edge traces against the skew rule and final C against a plain matrix product.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst, ld_valid, ld_mat, start;
  logic                 ld_ready, busy, acc_clr, done;
  logic [IW-1:0]        ld_idx;
  logic [N-1:0][DW-1:0] ld_row, A_in, B_in;

  int ma[N][N], mb[N][N];
  int pa[N][N], pb[N][N], ps[N][N];
  logic [N-1:0][DW-1:0] a_trace[3*N], b_trace[3*N];
  int total = 0, bad = 0, done_seen = 0, base;

  systolic_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_mat(ld_mat),
    .ld_idx(ld_idx), .ld_row(ld_row), .start(start), .busy(busy), .acc_clr(acc_clr),
    .A_in(A_in), .B_in(B_in), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  // Output-stationary PE grid: a moves right, b moves down, psum accumulates; cleared by rst|acc_clr.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int av, bv;
        if (j == 0) av = int'(A_in[i]); else av = pa[i][j-1];
        if (i == 0) bv = int'(B_in[j]); else bv = pb[i-1][j];
        if (rst || acc_clr) begin
          pa[i][j] <= 0;
          pb[i][j] <= 0;
          ps[i][j] <= 0;
        end else begin
          pa[i][j] <= av;
          pb[i][j] <= bv;
          ps[i][j] <= ps[i][j] + av * bv;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0][DW-1:0] exp_a(input int t);
    logic [N-1:0][DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i] = DW'(ma[i][t-i]);
    return v;
  endfunction

  function automatic logic [N-1:0][DW-1:0] exp_b(input int t);
    logic [N-1:0][DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j] = DW'(mb[t-j][j]);
    return v;
  endfunction

  function automatic int prod(input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
    return s;
  endfunction

  task automatic load_row(input bit mat, input int idx);
    ld_valid = 1'b1;
    ld_mat   = mat;
    ld_idx   = IW'(idx);
    for (int j = 0; j < N; j++) ld_row[j] = DW'(mat ? mb[idx][j] : ma[idx][j]);
    check("load_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < N; r++) begin
      load_row(1'b0, r);
      load_row(1'b1, r);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One run from the current IDLE cycle. inj_t: FEED step at which a load beat and a start are
  // presented (ignored by the DUT). abort_t: step at which rst is pulsed. pre_b2: load B row 2 = 9s
  // in the same cycle as start.
  task automatic run(input int inj_t, input int abort_t, input bit pre_b2);
    if (pre_b2) begin
      ld_valid = 1'b1;
      ld_mat   = 1'b1;
      ld_idx   = IW'(2);
      for (int j = 0; j < N; j++) begin
        ld_row[j] = DW'(9);
        mb[2][j]  = 9;
      end
    end
    start = 1'b1;
    check("start_ready", ld_ready, 1);
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    check("clr_flags", {acc_clr, busy, done, ld_ready}, 4'b1100);
    check("clr_edges", {A_in, B_in}, 64'h0);
    for (int t = 0; t <= 3*N - 3; t++) begin
      tick();
      start    = 1'b0;
      ld_valid = 1'b0;
      a_trace[t] = A_in;
      b_trace[t] = B_in;
      check($sformatf("skew_a_t%0d", t), A_in, exp_a(t));
      check($sformatf("skew_b_t%0d", t), B_in, exp_b(t));
      check($sformatf("run_flags_t%0d", t), {acc_clr, done, busy, ld_ready}, 4'b0010);
      if (t == abort_t) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_flags", {busy, done, acc_clr, ld_ready}, 4'b0001);
        check("abort_edges", {A_in, B_in}, 64'h0);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            ma[i][j] = 0;
            mb[i][j] = 0;
          end
        return;
      end
      if (t == inj_t) begin
        ld_valid = 1'b1;
        ld_mat   = 1'b0;
        ld_idx   = '0;
        for (int j = 0; j < N; j++) ld_row[j] = DW'(7);
        start = 1'b1;
      end
    end
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    check("done_flags", {done, busy, ld_ready, acc_clr}, 4'b1010);
    check("done_edges", {A_in, B_in}, 64'h0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("c_%0d_%0d", i, j), ps[i][j], prod(i, j));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_mat = 1'b0; ld_idx = '0; ld_row = '0; start = 1'b0;
    tick();
    tick();
    check("rst_flags", {busy, acc_clr, done, ld_ready}, 4'b0001);
    check("rst_edges", {A_in, B_in}, 64'h0);
    rst = 1'b0;
    tick();

    // Skew trace with distinguishable elements.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = 16*i + k;
        mb[i][k] = 16*i + k + 100;
      end
    load_all();
    run(-1, -1, 1'b0);
    check("t0_a", a_trace[0], 32'h0000_0000);
    check("t0_b", b_trace[0], 32'h0000_0064);
    check("t3_a", a_trace[3], 32'h3021_1203);
    check("t3_b", b_trace[3], 32'h6776_8594);
    check("t6_a", a_trace[6], 32'h3300_0000);
    check("t6_b", b_trace[6], 32'h9700_0000);

    // Identity A: C equals B; second run starts in the done cycle with no reload.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = (i == k) ? 1 : 0;
        mb[i][k] = i*4 + k;
      end
    load_all();
    run(-1, -1, 1'b0);
    run(-1, -1, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("ident_c_%0d_%0d", i, j), ps[i][j], i*4 + j);

    // Saturating operands; exactly one done pulse.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = 255;
        mb[i][k] = 255;
      end
    load_all();
    tick();
    base = done_seen;
    run(-1, -1, 1'b0);
    idle(3*N + 2);
    check("sat_done_once", done_seen - base, 1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("sat_c_%0d_%0d", i, j), ps[i][j], 260100);

    // Load beat and start while busy are both ignored.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = int'($urandom_range(0, 255));
        mb[i][k] = int'($urandom_range(0, 255));
      end
    load_all();
    run(-1, -1, 1'b0);
    tick();
    base = done_seen;
    run(2, -1, 1'b0);
    idle(3*N + 2);
    check("busy_start_ignored", done_seen - base, 1);
    run(-1, -1, 1'b0);

    // start together with a load beat: the new row is used.
    tick();
    run(-1, -1, 1'b1);
    check("same_cycle_b_t2", b_trace[2][0], 9);

    // Random matrices.
    repeat (3) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          ma[i][k] = int'($urandom_range(0, 255));
          mb[i][k] = int'($urandom_range(0, 255));
        end
      load_all();
      run(-1, -1, 1'b0);
    end

    // Reset mid-FEED: no done, buffers cleared, next run gives zeros.
    tick();
    base = done_seen;
    run(-1, 3, 1'b0);
    idle(3*N + 2);
    check("abort_no_done", done_seen - base, 0);
    run(-1, -1, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("zero_c_%0d_%0d", i, j), ps[i][j], 0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
